// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: control-transfer opcodes, branch funct3 codes,
// the redirect controller state type and a funct3 legality helper.
package rv32i_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } redir_state_e;

   // funct3 values 010 and 011 have no branch meaning in RV32I
   function automatic logic is_illegal_br_f3(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

endpackage

// File: rtl/branch_redirect_ctrl_branch_unit.sv
// Branch comparator: evaluates the RV32I branch condition selected by funct3.
// Undefined funct3 codes report not taken.
module Branch_Unit
   import rv32i_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        taken_o
);

   // Pure combinational compare, no state
   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = (a_i == b_i);
         F3_BNE:  taken_o = (a_i != b_i);
         F3_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
         F3_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
         F3_BLTU: taken_o = (a_i <  b_i);
         F3_BGEU: taken_o = (a_i >= b_i);
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: target calculation, taken decision,
// front-end flush, registered PC redirect with handshake, exception pulses
// and saturating branch statistics.
module branch_redirect_ctrl
   import rv32i_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jal,
   input  logic             ex_is_jalr,
   input  logic [2:0]       ex_funct3,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_imm,
   input  logic [31:0]      ex_rs1,
   input  logic [31:0]      ex_rs2,
   input  logic             redirect_ready,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush_front,
   output logic             fetch_hold,
   output logic             misalign_exc,
   output logic             illegal_br,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   redir_state_e     state_q, state_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic             misalign_q, misalign_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] br_count_q, br_count_d;
   logic [CNT_W-1:0] taken_count_q, taken_count_d;

   logic             bu_taken;
   logic [1:0]       type_sum;
   logic             resolve;
   logic             br_illegal;
   logic             taken;
   logic [31:0]      jalr_sum;
   logic [31:0]      target;
   logic             aligned;
   logic             redirect_go;

   Branch_Unit u_branch_unit (
      .funct3_i (ex_funct3),
      .a_i      (ex_rs1),
      .b_i      (ex_rs2),
      .taken_o  (bu_taken)
   );

   // Decode the EX instruction into a resolve decision and its target
   always_comb begin
      type_sum    = {1'b0, ex_is_branch} + {1'b0, ex_is_jal} + {1'b0, ex_is_jalr};
      // Several type flags at once is not a control transfer at all
      resolve     = ex_valid && (state_q == ST_IDLE) && (type_sum == 2'd1) && !rst;
      br_illegal  = ex_is_branch && is_illegal_br_f3(ex_funct3);
      taken       = ex_is_jal || ex_is_jalr || (ex_is_branch && bu_taken && !br_illegal);
      jalr_sum    = ex_rs1 + ex_imm;
      target      = ex_is_jalr ? (jalr_sum & ~32'd1) : (ex_pc + ex_imm);
      aligned     = (target[1:0] == 2'b00);
      redirect_go = resolve && taken && aligned;
   end

   // Next-state: FSM, redirect target, exception pulses, saturating counters
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      misalign_d    = resolve && taken && !aligned;
      illegal_d     = resolve && br_illegal;
      br_count_d    = br_count_q;
      taken_count_d = taken_count_q;

      case (state_q)
         ST_IDLE: begin
            if (redirect_go) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = target;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (resolve && ex_is_branch && (br_count_q != {CNT_W{1'b1}}))
         br_count_d = br_count_q + CNT_W'(1);
      if (redirect_go && (taken_count_q != {CNT_W{1'b1}}))
         taken_count_d = taken_count_q + CNT_W'(1);
   end

   // State registers with synchronous reset; reset also drops a pending redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         redirect_pc_q <= 32'd0;
         misalign_q    <= 1'b0;
         illegal_q     <= 1'b0;
         br_count_q    <= '0;
         taken_count_q <= '0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         misalign_q    <= misalign_d;
         illegal_q     <= illegal_d;
         br_count_q    <= br_count_d;
         taken_count_q <= taken_count_d;
      end
   end

   assign redirect_valid = (state_q == ST_REDIRECT);
   assign redirect_pc    = redirect_pc_q;
   assign flush_front    = redirect_go;
   assign fetch_hold     = (state_q == ST_REDIRECT) && !rst;
   assign misalign_exc   = misalign_q;
   assign illegal_br     = illegal_q;
   assign br_count       = br_count_q;
   assign taken_count    = taken_count_q;

endmodule
